// File: rtl/freq_div_pkg.sv
// Shared types and constants for the frequency-divider controller and its
// surrounding benches.
package freq_div_pkg;

    localparam int RATIO_W = 3;

    typedef logic [RATIO_W-1:0] ratio_t;

    // A ratio of zero would stall the divider, so it is rejected.
    localparam ratio_t ILLEGAL_RATIO = '0;

    typedef enum logic [2:0] {
        ST_INIT      = 3'd0,
        ST_IDLE      = 3'd1,
        ST_WAIT_EDGE = 3'd2,
        ST_APPLY     = 3'd3,
        ST_SETTLE    = 3'd4,
        ST_DONE      = 3'd5
    } state_t;

    // Width of a saturating counter that must be able to hold 'limit'.
    function automatic int sat_cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/freq_div_ctrl_if.sv
// Requester-side bus of the divider controller.
//
// Handshake: a requester raises req[i] with req_ratio slice i stable and keeps
// both held until it sees gnt[i]. gnt is a one-cycle completion pulse; err is
// valid only in the gnt cycle. A req still high after its gnt counts as a new
// request. busy and cur_ratio are status only.
interface freq_div_ctrl_if
    import freq_div_pkg::*;
#(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]         req;
    logic [N_REQ*RATIO_W-1:0] req_ratio;
    logic [N_REQ-1:0]         gnt;
    logic                     err;
    logic                     busy;
    ratio_t                   cur_ratio;

    // Requester side.
    modport master (
        output req, req_ratio,
        input  gnt, err, busy, cur_ratio
    );

    // Controller side.
    modport slave (
        input  req, req_ratio,
        output gnt, err, busy, cur_ratio
    );
endinterface

// File: rtl/freq_div_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first active request at or
// after the pointer, wrapping around.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    // Scan the requesters starting at ptr; first hit wins.
    always_comb begin
        logic [IW-1:0] j;
        grant = '0;
        idx   = '0;
        j     = '0;
        for (int k = 0; k < N; k++) begin
            j = IW'((int'(ptr) + k) % N);
            if (grant == '0 && req[j]) begin
                grant[j] = 1'b1;
                idx      = j;
            end
        end
    end

endmodule

// File: rtl/freq_div_ctrl.sv
// Owner of the divider ratio select and reset. Arbitrates ratio-change
// requests round-robin and applies each one glitch-safely: wait for a
// div_out falling edge, pulse the divider reset with the new ratio, then
// count div_out rising edges to confirm the divider is running again.
module freq_div_ctrl
    import freq_div_pkg::*;
#(
    parameter int     N_REQ         = 4,
    parameter ratio_t DEFAULT_RATIO = 3'd2,
    parameter int     RST_CYC       = 2,
    parameter int     SETTLE_EDGES  = 2,
    parameter int     TIMEOUT       = 64
) (
    input  logic            clk,
    input  logic            rst,
    freq_div_ctrl_if.slave  bus,
    output ratio_t          div_in,
    output logic            div_rst,
    input  logic            div_out,
    output state_t          dbg_state
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = sat_cnt_width(TIMEOUT);
    localparam int EW = sat_cnt_width(SETTLE_EDGES);

    localparam logic [CW-1:0] TO_LAST    = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] RST_LAST   = CW'(RST_CYC - 1);
    localparam logic [EW-1:0] EDGE_LAST  = EW'(SETTLE_EDGES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(N_REQ - 1);

    state_t             state;
    ratio_t             cur_ratio;
    ratio_t             new_ratio;
    logic               div_rst_r;
    logic               busy_r;
    logic               err_r;
    logic               err_flag;
    logic               has_owner;
    logic               div_q;
    logic [N_REQ-1:0]   gnt_r;
    logic [N_REQ-1:0]   owner_oh;
    logic [IW-1:0]      ptr;
    logic [CW-1:0]      cnt;
    logic [EW-1:0]      edge_cnt;

    logic [N_REQ-1:0]   arb_grant;
    logic [IW-1:0]      arb_idx;
    logic               arb_any;
    ratio_t             req_sel;
    ratio_t             req_ratio_a [N_REQ];
    logic               rise;
    logic               fall;
    logic               settle_done;
    logic               to_hit;

    // Unpack the flat ratio bus into one slice per requester.
    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign req_ratio_a[g] = bus.req_ratio[g*RATIO_W +: RATIO_W];
    end

    rr_arbiter #(
        .N  (N_REQ),
        .IW (IW)
    ) u_arb (
        .req   (bus.req),
        .ptr   (ptr),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    assign arb_any     = |arb_grant;
    assign req_sel     = req_ratio_a[arb_idx];
    assign rise        = div_out & ~div_q;
    assign fall        = ~div_out & div_q;
    assign settle_done = rise && (edge_cnt == EDGE_LAST);
    assign to_hit      = (cnt == TO_LAST);

    assign bus.gnt       = gnt_r;
    assign bus.err       = err_r;
    assign bus.busy      = busy_r;
    assign bus.cur_ratio = cur_ratio;
    assign div_in        = cur_ratio;
    assign div_rst       = div_rst_r;
    assign dbg_state     = state;

    // One-cycle history of div_out for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q <= 1'b0;
        end else begin
            div_q <= div_out;
        end
    end

    // Control FSM; every output is a register written here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_INIT;
            cur_ratio <= DEFAULT_RATIO;
            new_ratio <= DEFAULT_RATIO;
            div_rst_r <= 1'b0;
            busy_r    <= 1'b1;
            err_r     <= 1'b0;
            err_flag  <= 1'b0;
            has_owner <= 1'b0;
            gnt_r     <= '0;
            owner_oh  <= '0;
            ptr       <= '0;
            cnt       <= '0;
            edge_cnt  <= '0;
        end else begin
            gnt_r <= '0;
            err_r <= 1'b0;
            case (state)
                ST_INIT: begin
                    // Hold the divider in reset, then confirm it runs.
                    if (cnt == RST_LAST) begin
                        div_rst_r <= 1'b1;
                        has_owner <= 1'b0;
                        cnt       <= '0;
                        edge_cnt  <= '0;
                        state     <= ST_SETTLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_IDLE: begin
                    // The gnt cycle is skipped so a requester that has not
                    // yet dropped req is not granted twice.
                    if (gnt_r != '0) begin
                        busy_r <= 1'b0;
                    end else if (arb_any) begin
                        owner_oh  <= arb_grant;
                        new_ratio <= req_sel;
                        has_owner <= 1'b1;
                        busy_r    <= 1'b1;
                        cnt       <= '0;
                        ptr       <= (arb_idx == IDX_LAST) ? '0 : arb_idx + 1'b1;
                        if (req_sel == ILLEGAL_RATIO) begin
                            err_flag <= 1'b1;
                            state    <= ST_DONE;
                        end else if (req_sel == cur_ratio) begin
                            state <= ST_DONE;
                        end else begin
                            state <= ST_WAIT_EDGE;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end

                ST_WAIT_EDGE: begin
                    // Switch only right after a falling edge; a stuck
                    // divider is switched anyway and flagged.
                    if (fall || to_hit) begin
                        if (!fall) begin
                            err_flag <= 1'b1;
                        end
                        cur_ratio <= new_ratio;
                        div_rst_r <= 1'b0;
                        cnt       <= '0;
                        state     <= ST_APPLY;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_APPLY: begin
                    // Divider reset held for RST_CYC cycles.
                    if (cnt == RST_LAST) begin
                        div_rst_r <= 1'b1;
                        cnt       <= '0;
                        edge_cnt  <= '0;
                        state     <= ST_SETTLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_SETTLE: begin
                    // Count rising edges until lock or timeout.
                    if (settle_done || to_hit) begin
                        cnt      <= '0;
                        edge_cnt <= '0;
                        if (has_owner) begin
                            if (!settle_done) begin
                                err_flag <= 1'b1;
                            end
                            state <= ST_DONE;
                        end else begin
                            err_r  <= !settle_done;
                            busy_r <= 1'b0;
                            state  <= ST_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (rise) begin
                            edge_cnt <= edge_cnt + 1'b1;
                        end
                    end
                end

                ST_DONE: begin
                    // Completion pulse to the owner with the outcome.
                    gnt_r    <= owner_oh;
                    err_r    <= err_flag;
                    err_flag <= 1'b0;
                    state    <= ST_IDLE;
                end

                default: begin
                    state <= ST_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_freq_div_ctrl.sv
// Bench for freq_div_ctrl with a behavioural divider model and a scoreboard
// of expected {err, gnt, cur_ratio} at each completion pulse.
module tb_freq_div_ctrl;
    import freq_div_pkg::*;

    localparam int N_REQ = 4;
    localparam int W     = 1 + N_REQ + RATIO_W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    freq_div_ctrl_if #(.N_REQ(N_REQ)) bus ();

    ratio_t div_in;
    logic   div_rst;
    logic   div_out = 1'b0;
    state_t dbg_state;

    freq_div_ctrl #(
        .N_REQ         (N_REQ),
        .DEFAULT_RATIO (3'd2),
        .RST_CYC       (2),
        .SETTLE_EDGES  (2),
        .TIMEOUT       (64)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .div_in    (div_in),
        .div_rst   (div_rst),
        .div_out   (div_out),
        .dbg_state (dbg_state)
    );

    // ---------------- divider model ----------------
    // Toggles every div_in cycles while running; 'stuck' freezes it low.
    logic stuck = 1'b0;
    int   dcnt  = 0;
    always @(negedge clk) begin
        if (!div_rst) begin
            dcnt    = 0;
            div_out = 1'b0;
        end else if (stuck) begin
            div_out = 1'b0;
        end else if (dcnt >= int'(div_in) - 1) begin
            dcnt    = 0;
            div_out = ~div_out;
        end else begin
            dcnt++;
        end
    end

    // ---------------- scoreboard ----------------
    int             errors = 0;
    int             checks = 0;
    logic [W-1:0]   exp_q[$];
    logic [W-1:0]   sb_exp;
    logic [W-1:0]   sb_obs;

    always @(posedge clk) begin
        #1;
        if (rst && bus.gnt !== '0) begin
            checks++;
            sb_obs = {bus.err, bus.gnt, bus.cur_ratio};
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_gnt: got err/gnt/ratio=%b, required no grant", sb_obs);
            end else begin
                sb_exp = exp_q.pop_front();
                if (sb_obs !== sb_exp) begin
                    errors++;
                    $display("FAIL sb_gnt: got err/gnt/ratio=%b, required %b", sb_obs, sb_exp);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input ratio_t r);
        bus.req_ratio[i*RATIO_W +: RATIO_W] = r;
        bus.req[i] = 1'b1;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (!(bus.busy === 1'b0 && bus.gnt === '0) && n < budget) begin
            cyc();
            n++;
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_timeout: busy=%b after %0d cycles, required 0", bus.busy, n);
        end
    endtask

    task automatic init_sequence(input string tag);
        int   rises;
        int   n;
        logic prev;
        rst = 1'b1;
        cyc();
        checks++;
        if (div_rst !== 1'b0) begin
            errors++;
            $display("FAIL %s_div_rst_cyc1: got %b, required 0", tag, div_rst);
        end
        cyc();
        checks++;
        if (div_rst !== 1'b1) begin
            errors++;
            $display("FAIL %s_div_rst_cyc2: got %b, required 1", tag, div_rst);
        end
        rises = 0;
        n     = 0;
        prev  = div_out;
        while (bus.busy !== 1'b0 && n < 100) begin
            cyc();
            if (div_out && !prev) rises++;
            prev = div_out;
            n++;
        end
        checks++;
        if (bus.busy !== 1'b0 || rises != 2) begin
            errors++;
            $display("FAIL %s_settle: busy=%b rises=%0d, required busy=0 rises=2", tag, bus.busy, rises);
        end
        checks++;
        if (bus.err !== 1'b0) begin
            errors++;
            $display("FAIL %s_settle_err: got %b, required 0", tag, bus.err);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        bus.req = '0;
        bus.req_ratio = '0;
        repeat (3) cyc();
        checks++;
        if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL rst_gnt: got %b, required 0000", bus.gnt); end
        checks++;
        if (div_in !== 3'd2) begin errors++; $display("FAIL rst_div_in: got %0d, required 2", div_in); end
        checks++;
        if (div_rst !== 1'b0) begin errors++; $display("FAIL rst_div_rst: got %b, required 0", div_rst); end
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL rst_busy: got %b, required 1", bus.busy); end
        checks++;
        if (bus.err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b, required 0", bus.err); end
        checks++;
        if (dbg_state !== ST_INIT) begin errors++; $display("FAIL rst_state: got %0d, required %0d", dbg_state, ST_INIT); end
        init_sequence("init");
    endtask

    task automatic test_contention();
        int n;
        int got;
        wait_idle(50);
        exp_q.push_back({1'b0, 4'b0001, 3'd3});
        exp_q.push_back({1'b0, 4'b0100, 3'd4});
        exp_q.push_back({1'b0, 4'b1000, 3'd6});
        set_req(0, 3'd3);
        set_req(2, 3'd4);
        set_req(3, 3'd6);
        n   = 0;
        got = 0;
        while (got < 3 && n < 600) begin
            cyc();
            if (bus.gnt !== '0) begin
                got++;
                bus.req = bus.req & ~bus.gnt;
            end
            n++;
        end
        checks++;
        if (got != 3) begin errors++; $display("FAIL cont_grants: got %0d grants, required 3", got); end
        checks++;
        if (bus.cur_ratio !== 3'd6 || div_in !== 3'd6) begin
            errors++;
            $display("FAIL cont_final_ratio: got %0d/%0d, required 6", bus.cur_ratio, div_in);
        end
    endtask

    task automatic test_single();
        int     n;
        int     lows;
        int     rises;
        logic   prev_out;
        ratio_t prev_in;
        wait_idle(50);
        exp_q.push_back({1'b0, 4'b0010, 3'd5});
        set_req(1, 3'd5);
        prev_out = div_out;
        prev_in  = div_in;
        n = 0;
        while (div_in === prev_in && n < 200) begin
            prev_out = div_out;
            cyc();
            n++;
        end
        checks++;
        if (div_in !== 3'd5 || !(prev_out === 1'b1 && div_out === 1'b0)) begin
            errors++;
            $display("FAIL single_apply_on_fall: div_in=%0d out %b->%b, required 5 on 1->0", div_in, prev_out, div_out);
        end
        lows = 0;
        while (div_rst === 1'b0 && lows < 10) begin
            lows++;
            cyc();
        end
        checks++;
        if (lows != 2) begin errors++; $display("FAIL single_rst_len: got %0d cycles, required 2", lows); end
        rises    = 0;
        n        = 0;
        prev_out = div_out;
        while (bus.gnt === '0 && n < 200) begin
            cyc();
            if (div_out && !prev_out) rises++;
            prev_out = div_out;
            n++;
        end
        bus.req[1] = 1'b0;
        checks++;
        if (bus.gnt !== 4'b0010 || bus.err !== 1'b0 || rises != 2) begin
            errors++;
            $display("FAIL single_gnt: gnt=%b err=%b rises=%0d, required 0010 0 2", bus.gnt, bus.err, rises);
        end
    endtask

    task automatic test_degenerate();
        int lows;
        // Illegal ratio zero.
        wait_idle(50);
        exp_q.push_back({1'b1, 4'b0100, 3'd5});
        set_req(2, 3'd0);
        cyc();
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL illegal_busy: got %b, required 1", bus.busy); end
        cyc();
        bus.req[2] = 1'b0;
        checks++;
        if (bus.gnt !== 4'b0100 || bus.err !== 1'b1 || div_in !== 3'd5) begin
            errors++;
            $display("FAIL illegal_gnt: gnt=%b err=%b div_in=%0d, required 0100 1 5", bus.gnt, bus.err, div_in);
        end
        // Same ratio as current.
        wait_idle(50);
        exp_q.push_back({1'b0, 4'b1000, 3'd5});
        set_req(3, 3'd5);
        lows = 0;
        cyc();
        if (div_rst !== 1'b1) lows++;
        cyc();
        if (div_rst !== 1'b1) lows++;
        bus.req[3] = 1'b0;
        checks++;
        if (bus.gnt !== 4'b1000 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL same_gnt: gnt=%b err=%b, required 1000 0", bus.gnt, bus.err);
        end
        checks++;
        if (lows != 0) begin errors++; $display("FAIL same_no_rst: div_rst low %0d cycles, required 0", lows); end
    endtask

    task automatic test_stuck();
        int n;
        int wait_n;
        int settle_n;
        wait_idle(50);
        stuck = 1'b1;
        exp_q.push_back({1'b1, 4'b0001, 3'd7});
        set_req(0, 3'd7);
        n        = 0;
        wait_n   = 0;
        settle_n = 0;
        while (bus.gnt === '0 && n < 400) begin
            cyc();
            if (dbg_state === ST_WAIT_EDGE) wait_n++;
            if (dbg_state === ST_SETTLE) settle_n++;
            n++;
        end
        bus.req[0] = 1'b0;
        stuck = 1'b0;
        checks++;
        if (bus.gnt !== 4'b0001 || bus.err !== 1'b1) begin
            errors++;
            $display("FAIL stuck_gnt: gnt=%b err=%b, required 0001 1", bus.gnt, bus.err);
        end
        checks++;
        if (wait_n != 64 || settle_n != 64) begin
            errors++;
            $display("FAIL stuck_timeouts: wait=%0d settle=%0d, required 64 64", wait_n, settle_n);
        end
    endtask

    task automatic test_reset_mid_apply();
        int n;
        wait_idle(50);
        set_req(1, 3'd4);
        n = 0;
        while (dbg_state !== ST_APPLY && n < 200) begin
            cyc();
            n++;
        end
        checks++;
        if (dbg_state !== ST_APPLY) begin errors++; $display("FAIL mid_reach_apply: state=%0d, required %0d", dbg_state, ST_APPLY); end
        #2;
        rst = 1'b0;
        #1;
        bus.req = '0;
        checks++;
        if (bus.gnt !== 4'b0000 || div_in !== 3'd2 || div_rst !== 1'b0 || bus.busy !== 1'b1 || dbg_state !== ST_INIT) begin
            errors++;
            $display("FAIL mid_reset_values: gnt=%b div_in=%0d div_rst=%b busy=%b state=%0d, required 0000 2 0 1 %0d",
                     bus.gnt, div_in, div_rst, bus.busy, dbg_state, ST_INIT);
        end
        cyc();
        cyc();
        init_sequence("mid");
        repeat (10) cyc();
        checks++;
        if (div_in !== 3'd2 || dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL mid_final: div_in=%0d state=%0d, required 2 %0d", div_in, dbg_state, ST_IDLE);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        bus.req       = '0;
        bus.req_ratio = '0;
        test_reset();
        test_contention();
        test_single();
        test_degenerate();
        test_stuck();
        test_reset_mid_apply();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drained: %0d grants outstanding, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/freq_div_ctrl.md
Name: freq_div_ctrl

Overview:
Controller that owns the 3-bit ratio select and reset of the frequency divider and shares it between N_REQ requesters. Requests are arbitrated round-robin. Each granted ratio change is applied glitch-safely: wait for a div_out falling edge, pulse the divider reset, then confirm settling by counting div_out edges. It sits between software/config requesters and the divider instance, in the same clk domain.

Parameters:
N_REQ, 4, number of requesters (2..8)
RATIO_W, 3, width of ratio select
DEFAULT_RATIO, 3'd2, ratio applied after reset
RST_CYC, 2, cycles div_rst is held asserted per change (>=1)
SETTLE_EDGES, 2, div_out rising edges required to declare lock (>=1)
TIMEOUT, 64, cycle limit for WAIT_EDGE and for SETTLE

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
req  in  N_REQ  per-requester change request, level, held until gnt
req_ratio  in  N_REQ*RATIO_W  requested ratio, slice i for requester i
gnt  out  N_REQ  one-hot, 1-cycle completion pulse
err  out  1  1-cycle pulse coincident with gnt when the change failed or was forced
busy  out  1  high from capture until the cycle after gnt
cur_ratio  out  RATIO_W  ratio currently driven to the divider
div_in  out  RATIO_W  ratio select to divider (equals cur_ratio)
div_rst  out  1  divider reset, active-low
div_out  in  1  divider output, synchronous to clk

Behaviour:
- Clock is clk. Reset is rst: asynchronous, active-low, single clock domain.
- Reset values: state=INIT, cur_ratio/div_in=DEFAULT_RATIO, div_rst=0 (asserted), gnt=0, err=0, busy=1, RR pointer=0, counters=0.
- All outputs are registered. div_out is sampled once per cycle (div_q). rise = div_out & ~div_q; fall = ~div_out & div_q. div_q resets to 0.
- FSM states: INIT, IDLE, WAIT_EDGE, APPLY, SETTLE, DONE.
- INIT:
  - Hold div_rst=0 for RST_CYC cycles after rst deasserts, then go to SETTLE with no owner.
  - Exiting SETTLE without an owner goes to IDLE and gives no gnt. On timeout, err still pulses.
- IDLE:
  - busy=0.
  - If any req is high, the round-robin arbiter picks the first requester at or after the pointer.
  - Latch owner index and its ratio (new_ratio). Pointer becomes owner+1 mod N_REQ. busy=1 next cycle.
  - If new_ratio==0 (illegal), go to DONE with err=1 and no divider change.
  - If new_ratio==cur_ratio, go to DONE with no divider change and no err.
  - Otherwise go to WAIT_EDGE.
- WAIT_EDGE:
  - On fall, go to APPLY.
  - If TIMEOUT cycles elapse with no fall (divider stuck), go to APPLY anyway and set err_flag.
- APPLY:
  - On entry, cur_ratio/div_in=new_ratio and div_rst=0.
  - Hold for RST_CYC cycles, then set div_rst=1 and go to SETTLE.
- SETTLE:
  - Count rise events.
  - Reaching SETTLE_EDGES goes to DONE.
  - TIMEOUT cycles without reaching it goes to DONE with err_flag set. cur_ratio is retained.
- DONE:
  - gnt[owner]=1 for exactly 1 cycle. err=err_flag. Clear err_flag. Return to IDLE.
  - busy falls the cycle after gnt.
- Latency, same-ratio request: req high in IDLE at cycle t, gnt at t+2.
- Requests:
  - Requests are captured once. A req drop after capture does not abort the change; gnt still pulses.
  - A req not granted is simply re-arbitrated later. A requester still holding req after its gnt is treated as a new request.
- Simultaneous requests: only one owner per transaction. Others wait; there is no starvation (round-robin).
- Reset mid-operation: immediate return to reset values. The divider is re-reset with DEFAULT_RATIO and the pending request is lost (no gnt).
- Counters are sized $clog2(TIMEOUT+1) and saturate; they never wrap.

Decomposition:
- Shared package freq_div_pkg:
  - state enum type
  - RATIO_W
  - ILLEGAL_RATIO=0
  - a ratio_t typedef (shared with the divider testbench)
- One sub-module, rr_arbiter:
  - parameter N
  - inputs req, ptr
  - outputs onehot grant and index
  - combinational

Test Plan:
- Reset → gnt stays 0; div_in=2; div_rst=0 for 2 cycles, then 1; busy drops after 2 div_out rises.
- Single change: req[1] with ratio 5, divider running → div_in becomes 5 only after a div_out fall; div_rst low for exactly 2 cycles; gnt[1] after 2 rises; err=0.
- Contention: req[0]=3, req[2]=4, req[3]=6 raised in the same cycle, pointer=0 → grants in order 0, 2, 3, one transaction at a time; cur_ratio ends at 6.
- Degenerate ratios: req[2] with ratio 0 → gnt[2] and err=1 at t+2, div_in unchanged. Ratio equal to cur_ratio → gnt at t+2, err=0, div_rst never asserted.
- Stuck divider: div_out held 0 → WAIT_EDGE times out after 64 cycles, APPLY proceeds, SETTLE times out after 64 more; gnt with err=1.
- Reset mid-APPLY: rst low during APPLY → gnt never fires; div_in=2; INIT sequence repeats.
